// File: rtl/stack.sv
// Parameterised LIFO stack: DEPTH x WIDTH storage, occupancy pointer sp,
// registered pop output and combinational full/empty decodes.
module stack #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH:0]   sp;
  logic [ADDR_WIDTH:0]   sp_dec;
  logic [ADDR_WIDTH-1:0] top_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  do_pop;
  logic                  do_swap;
  logic                  wr_en;

  always_comb begin
    full    = (sp == FULL_COUNT);
    empty   = (sp == '0);
    sp_dec  = sp - 1'b1;
    top_idx = sp_dec[ADDR_WIDTH-1:0];
    do_pop  = pop && !empty;
    do_swap = push && do_pop;
    // A simultaneous push/pop on a non-empty stack overwrites the top in place,
    // so it is allowed even when full; a push into an empty stack ignores pop.
    wr_en   = push && (do_swap || !full);
    wr_idx  = do_swap ? top_idx : sp[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp       <= '0;
      data_out <= '0;
    end else begin
      if (do_pop) begin
        data_out <= mem[top_idx];
      end
      if (wr_en && !do_swap) begin
        sp <= sp + 1'b1;
      end else if (do_pop && !push) begin
        sp <= sp_dec;
      end
    end
  end

  // Storage is deliberately not reset; entries above sp are unreachable.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wr_idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_stack.sv
// Self-checking bench for stack: directed scenarios followed by random
// push/pop traffic, all compared against a queue-based LIFO model.
module tb_stack;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 8;
  localparam int ADDR_WIDTH = 3;

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] model_dout;

  stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"}, 32'(data_out), 32'(model_dout));
    check({tag, ".full"},     32'(full),     32'(model_q.size() == DEPTH));
    check({tag, ".empty"},    32'(empty),    32'(model_q.size() == 0));
  endtask

  // LIFO behaviour straight from the rules, applied after each rising edge.
  task automatic model_step(input logic p, input logic po, input logic [WIDTH-1:0] din);
    if (p && po && model_q.size() > 0) begin
      model_dout = model_q[$];
      model_q[model_q.size()-1] = din;
    end else if (p) begin
      if (model_q.size() < DEPTH) model_q.push_back(din);
    end else if (po && model_q.size() > 0) begin
      model_dout = model_q.pop_back();
    end
  endtask

  task automatic step(input string tag, input logic p, input logic po, input logic [WIDTH-1:0] din);
    @(negedge clk);
    push    = p;
    pop     = po;
    data_in = din;
    @(posedge clk);
    model_step(p, po, din);
    #1;
    check_all(tag);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_q.delete();
    model_dout = '0;
    check_all("reset_async");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    push = 1'b0; pop = 1'b0; data_in = '0;
    model_dout = '0;
    reset = 1'b0;
    #1;
    check_all("reset_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Push three, pop one
    step("p10", 1, 0, 8'd10);
    step("p20", 1, 0, 8'd20);
    step("p30", 1, 0, 8'd30);
    step("pop30", 0, 1, 8'd0);
    check("pop30.const", 32'(data_out), 32'd30);

    step("p40", 1, 0, 8'd40);
    step("pop40", 0, 1, 8'd0);
    check("pop40.const", 32'(data_out), 32'd40);
    step("pop20", 0, 1, 8'd0);
    step("pop10", 0, 1, 8'd0);
    check("pop10.empty", 32'(empty), 32'd1);

    // Pop while empty holds data_out
    step("pop_empty", 0, 1, 8'd0);
    check("pop_empty.const", 32'(data_out), 32'd10);

    // Fill to full, overflow push ignored
    for (int i = 1; i <= DEPTH; i++) step("fill", 1, 0, 8'(i));
    check("fill.full", 32'(full), 32'd1);
    step("push_full", 1, 0, 8'd99);
    step("pop_after_full", 0, 1, 8'd0);
    check("pop_after_full.const", 32'(data_out), 32'd8);

    // Drain, then simultaneous push/pop
    while (model_q.size() > 0) step("drain", 0, 1, 8'd0);
    step("p5", 1, 0, 8'd5);
    step("p6", 1, 0, 8'd6);
    step("swap7", 1, 1, 8'd7);
    check("swap7.const", 32'(data_out), 32'd6);
    step("pop7", 0, 1, 8'd0);
    step("pop5", 0, 1, 8'd0);
    check("pop5.const", 32'(data_out), 32'd5);

    // Simultaneous push/pop while empty acts as push
    step("swap_empty", 1, 1, 8'd33);
    // Simultaneous push/pop while full replaces the top
    for (int i = 0; i < DEPTH - 1; i++) step("refill", 1, 0, 8'(50 + i));
    step("swap_full", 1, 1, 8'd77);
    step("pop_swapped", 0, 1, 8'd0);

    // Reset mid-operation, then pop is ignored
    step("pr1", 1, 0, 8'd1);
    step("pr2", 1, 0, 8'd2);
    step("pr3", 1, 0, 8'd3);
    do_reset();
    step("pop_after_reset", 0, 1, 8'd0);
    check("pop_after_reset.const", 32'(data_out), 32'd0);

    // Random traffic with phase-dependent push bias to reach both ends
    for (int i = 0; i < 400; i++) begin
      int unsigned bias;
      logic rp, rpo;
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      rp   = ($urandom_range(99) < bias);
      rpo  = ($urandom_range(99) < (100 - bias));
      step("rand", rp, rpo, 8'($urandom));
      if (i == 200) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
